epoch_scheduler: RTL

Sequences the per-sample phase controller across a full training run. For each epoch it issues one train request per training sample, then one validation request per validation sample. Each request waits for the phase controller's completion pulse before the next is issued. The block drives the sample address into the sample memory, counts validation misses per epoch, and reports run completion or a watchdog fault to the host-side control logic.

---
 rtl/nn_ctrl_pkg.sv | 41 ++++
 rtl/sched_watchdog.sv | 38 +++
 rtl/epoch_scheduler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/nn_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_ctrl_pkg
//  Description : Shared scheduler state encoding, default sizing constants
//                and port-width helpers for the training-run controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package nn_ctrl_pkg;

    localparam int c_n_train  = 64;
    localparam int c_n_val    = 16;
    localparam int c_n_epoch  = 8;
    localparam int c_wdog_max = 255;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        T_ISSUE = 3'd1,
        T_WAIT  = 3'd2,
        V_ISSUE = 3'd3,
        V_WAIT  = 3'd4,
        EP_END  = 3'd5,
        FIN     = 3'd6,
        FAULT   = 3'd7
    } sched_state_t;

    function automatic int addr_width(input int n_train, input int n_val);
        int n_max;
        n_max = (n_train > n_val) ? n_train : n_val;
        return (n_max > 1) ? $clog2(n_max) : 1;
    endfunction

    function automatic int epoch_width(input int n_epoch);
        return (n_epoch > 1) ? $clog2(n_epoch) : 1;
    endfunction

    function automatic int verr_width(input int n_val);
        return $clog2(n_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sched_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : sched_watchdog
//  Description : Completion-wait timeout counter with clear, enable and
//                expiry compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module sched_watchdog
    import nn_ctrl_pkg::*;
#(
    parameter int WDOG_MAX = c_wdog_max
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int c_cw = $clog2(WDOG_MAX + 1);

    logic [c_cw-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Flags the cycle whose increment would bring the count to WDOG_MAX.
    assign o_expired = (r_count == c_cw'(WDOG_MAX - 1));

endmodule
`default_nettype wire

// File: rtl/epoch_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : epoch_scheduler
//  Description : Sequences train/validation requests over a full training
//                run; optional macro EARLY_STOP_EN ends on a miss-free epoch.
//  Revision    : 1.0 - initial release
// ============================================================================
module epoch_scheduler
    import nn_ctrl_pkg::*;
#(
    parameter int N_TRAIN  = c_n_train,
    parameter int N_VAL    = c_n_val,
    parameter int N_EPOCH  = c_n_epoch,
    parameter int WDOG_MAX = c_wdog_max,
    localparam int AW      = addr_width(N_TRAIN, N_VAL),
    localparam int EW      = epoch_width(N_EPOCH),
    localparam int VW      = verr_width(N_VAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    output logic          tr,
    output logic          vl,
    input  logic          s_train,
    input  logic          s_error,
    input  logic          val_miss,
    output logic [AW-1:0] sample_addr,
    output logic [EW-1:0] epoch,
    output logic [VW-1:0] val_err,
    output logic          busy,
    output logic          done,
    output logic          fault
);

    localparam logic [AW-1:0] c_last_train = AW'(N_TRAIN - 1);
    localparam logic [AW-1:0] c_last_val   = AW'(N_VAL - 1);
    localparam logic [EW-1:0] c_last_epoch = EW'(N_EPOCH - 1);

    sched_state_t    r_state;
    sched_state_t    w_state_nxt;
    logic            r_s_train;
    logic            r_s_error;
    logic            r_val_miss;
    logic [VW-1:0]   r_miss_cnt;
    logic            w_wdog_clr;
    logic            w_wdog_en;
    logic            w_wdog_expired;
    logic            w_stop;
    logic            w_abort_hit;
    logic            w_run_start;

    // Completion pulses are registered first, so a pulse in cycle n yields
    // the next request in cycle n+2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s_train  <= 1'b0;
            r_s_error  <= 1'b0;
            r_val_miss <= 1'b0;
        end else begin
            r_s_train  <= s_train;
            r_s_error  <= s_error;
            r_val_miss <= val_miss;
        end
    end

    assign w_abort_hit = abort && (r_state != IDLE);
    assign w_run_start = start && !abort && ((r_state == IDLE) || (r_state == FAULT));
    assign w_wdog_clr  = (r_state == T_ISSUE) || (r_state == V_ISSUE);
    assign w_wdog_en   = ((r_state == T_WAIT) && !r_s_train) ||
                         ((r_state == V_WAIT) && !r_s_error);

`ifdef EARLY_STOP_EN
    assign w_stop = (epoch == c_last_epoch) || (r_miss_cnt == '0);
`else
    assign w_stop = (epoch == c_last_epoch);
`endif

    sched_watchdog #(
        .WDOG_MAX (WDOG_MAX)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_wdog_clr),
        .i_en      (w_wdog_en),
        .o_expired (w_wdog_expired)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, FAULT: if (w_run_start) w_state_nxt = T_ISSUE;
            T_ISSUE:     w_state_nxt = T_WAIT;
            T_WAIT: begin
                if (r_s_train)
                    w_state_nxt = (sample_addr == c_last_train) ? V_ISSUE : T_ISSUE;
                else if (w_wdog_expired)
                    w_state_nxt = FAULT;
            end
            V_ISSUE:     w_state_nxt = V_WAIT;
            V_WAIT: begin
                if (r_s_error)
                    w_state_nxt = (sample_addr == c_last_val) ? EP_END : V_ISSUE;
                else if (w_wdog_expired)
                    w_state_nxt = FAULT;
            end
            EP_END:      w_state_nxt = w_stop ? FIN : T_ISSUE;
            FIN:         w_state_nxt = IDLE;
            default:     w_state_nxt = IDLE;
        endcase
        if (w_abort_hit)
            w_state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            sample_addr <= '0;
            epoch       <= '0;
            val_err     <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_run_start) begin
                sample_addr <= '0;
                epoch       <= '0;
                r_miss_cnt  <= '0;
            end else if (!w_abort_hit) begin
                case (r_state)
                    T_WAIT: begin
                        if (r_s_train)
                            sample_addr <= (sample_addr == c_last_train) ? '0 : sample_addr + 1'b1;
                    end
                    V_WAIT: begin
                        if (r_s_error) begin
                            r_miss_cnt  <= r_miss_cnt + VW'(r_val_miss);
                            sample_addr <= (sample_addr == c_last_val) ? '0 : sample_addr + 1'b1;
                        end
                    end
                    EP_END: begin
                        val_err    <= r_miss_cnt;
                        r_miss_cnt <= '0;
                        if (!w_stop)
                            epoch <= epoch + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tr    = (r_state == T_ISSUE);
    assign vl    = (r_state == V_ISSUE);
    assign done  = (r_state == FIN);
    assign fault = (r_state == FAULT);
    assign busy  = (r_state != IDLE) && (r_state != FAULT);

endmodule
`default_nettype wire
